// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer feeding the exception side of CP0 and the fetch redirect.
// Optional macro EXC_CTRL_IRQ_SYNC_EN adds a two-flop synchroniser on every irq line.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0040_0004,
    parameter int          NUM_IRQ      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [31:0]        ex_pc,
    input  logic               ex_syscall,
    input  logic               ex_break,
    input  logic               ex_teq,
    input  logic               ex_eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [31:0]        status,
    input  logic [31:0]        epc,
    output logic               exception,
    output logic               eret,
    output logic [31:0]        cause,
    output logic [31:0]        exc_pc,
    output logic               stall,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    input  logic               redirect_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        ERET  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] irq_rise_s;
    logic               exception_r;
    logic               eret_r;
    logic               redirect_valid_r;
    logic [31:0]        cause_r;
    logic [31:0]        exc_pc_r;
    logic [31:0]        redirect_pc_r;
    logic               en_int_s;
    logic               en_teq_s;
    logic               en_brk_s;
    logic               en_sys_s;
    logic               idle_s;
    logic               take_exc_s;
    logic               take_eret_s;
    logic               take_int_s;
    logic [7:0]         ip_s;
    logic [4:0]         exc_code_s;
    logic [31:0]        cause_s;
    logic               unused_status_s;

    assign unused_status_s = ^status[31:5];

`ifdef EXC_CTRL_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_meta_r;
    logic [NUM_IRQ-1:0] irq_sync_r;
    logic [NUM_IRQ-1:0] irq_prev_r;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_meta_r <= {NUM_IRQ{1'b0}};
            irq_sync_r <= {NUM_IRQ{1'b0}};
            irq_prev_r <= {NUM_IRQ{1'b0}};
        end else begin
            irq_meta_r <= irq;
            irq_sync_r <= irq_meta_r;
            irq_prev_r <= irq_sync_r;
        end
    end

    assign irq_rise_s = irq_sync_r & ~irq_prev_r;
`else
    logic [NUM_IRQ-1:0] irq_prev_r;

    // Delayed copy of irq for direct edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_prev_r <= {NUM_IRQ{1'b0}};
        end else begin
            irq_prev_r <= irq;
        end
    end

    assign irq_rise_s = irq & ~irq_prev_r;
`endif

    assign en_int_s    = (|pending_r) & status[0] & status[4];
    assign en_teq_s    = ex_teq     & status[0] & status[3];
    assign en_brk_s    = ex_break   & status[0] & status[2];
    assign en_sys_s    = ex_syscall & status[0] & status[1];
    assign idle_s      = (state_r == IDLE);
    assign take_exc_s  = idle_s & ex_valid & (en_int_s | en_teq_s | en_brk_s | en_sys_s);
    assign take_eret_s = idle_s & ex_valid & ex_eret & ~(en_int_s | en_teq_s | en_brk_s | en_sys_s);
    assign take_int_s  = take_exc_s & en_int_s;

    // Highest-priority enabled event selects ExcCode; IP snapshot only for interrupts.
    always_comb begin
        ip_s       = 8'h00;
        exc_code_s = 5'd8;
        if (en_int_s) begin
            ip_s[NUM_IRQ-1:0] = pending_r;
            exc_code_s        = 5'd0;
        end else if (en_teq_s) begin
            exc_code_s = 5'd13;
        end else if (en_brk_s) begin
            exc_code_s = 5'd9;
        end else begin
            exc_code_s = 5'd8;
        end
        cause_s = {16'h0000, ip_s, 1'b0, exc_code_s, 2'b00};
    end

    // Next-state logic and the combinational pipeline stall.
    always_comb begin
        next_state_s = state_r;
        stall        = ~idle_s | take_exc_s | take_eret_s;
        case (state_r)
            IDLE: begin
                if (take_exc_s) begin
                    next_state_s = TRAP;
                end else if (take_eret_s) begin
                    next_state_s = ERET;
                end else begin
                    next_state_s = IDLE;
                end
            end
            TRAP:    next_state_s = REDIR;
            ERET:    next_state_s = REDIR;
            REDIR: begin
                if (redirect_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REDIR;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Pending interrupts; a fresh edge in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= {NUM_IRQ{1'b0}};
        end else if (take_int_s) begin
            pending_r <= irq_rise_s;
        end else begin
            pending_r <= pending_r | irq_rise_s;
        end
    end

    // Registered CP0 and redirect outputs, derived from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exception_r      <= 1'b0;
            eret_r           <= 1'b0;
            redirect_valid_r <= 1'b0;
            cause_r          <= 32'h0000_0000;
            exc_pc_r         <= 32'h0000_0000;
            redirect_pc_r    <= 32'h0000_0000;
        end else begin
            exception_r      <= (next_state_s == TRAP);
            eret_r           <= (next_state_s == ERET);
            redirect_valid_r <= (next_state_s == REDIR);
            if (take_exc_s) begin
                cause_r       <= cause_s;
                exc_pc_r      <= ex_pc;
                redirect_pc_r <= HANDLER_ADDR;
            end else if (take_eret_s) begin
                redirect_pc_r <= epc;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    assign exception      = exception_r;
    assign eret           = eret_r;
    assign redirect_valid = redirect_valid_r;
    assign cause          = cause_r;
    assign exc_pc         = exc_pc_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_exc_ctrl;
    localparam int          NIRQ    = 4;
    localparam logic [31:0] HANDLER = 32'h0040_0004;
`ifdef EXC_CTRL_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic            clk, rst;
    logic            ex_valid, ex_syscall, ex_break, ex_teq, ex_eret;
    logic [31:0]     ex_pc, status, epc;
    logic [NIRQ-1:0] irq;
    logic            exception, eret, stall, redirect_valid, redirect_ready;
    logic [31:0]     cause, exc_pc, redirect_pc;

    int checks = 0;
    int errors = 0;

    exc_ctrl #(.HANDLER_ADDR(HANDLER), .NUM_IRQ(NIRQ)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_syscall(ex_syscall), .ex_break(ex_break), .ex_teq(ex_teq), .ex_eret(ex_eret),
        .irq(irq), .status(status), .epc(epc),
        .exception(exception), .eret(eret), .cause(cause), .exc_pc(exc_pc),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a handled event is "busy" until the redirect is taken.
    bit              m_busy;
    int              m_phase;
    bit              m_exc, m_eret, m_rv;
    logic [31:0]     m_cause, m_excpc, m_rpc;
    bit [NIRQ-1:0]   m_pend;
    bit [NIRQ-1:0]   m_hist [4];

    task automatic m_reset();
        m_busy = 0; m_phase = 0; m_exc = 0; m_eret = 0; m_rv = 0;
        m_cause = 32'h0; m_excpc = 32'h0; m_rpc = 32'h0; m_pend = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
    endtask

    // ExcCode of the winning enabled exception/interrupt, or -1 if none.
    function automatic int m_code();
        if ((|m_pend) && status[0] && status[4]) return 0;
        if (ex_teq && status[0] && status[3])     return 13;
        if (ex_break && status[0] && status[2])   return 9;
        if (ex_syscall && status[0] && status[1]) return 8;
        return -1;
    endfunction

    function automatic bit m_accept();
        return !m_busy && ex_valid && (m_code() >= 0 || ex_eret);
    endfunction

    task automatic m_edge();
        bit [NIRQ-1:0] rise;
        int code;
        bit acc;
        logic [7:0] ip;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = irq;
        rise = m_hist[LAT] & ~m_hist[LAT+1];
        code = m_code();
        acc  = m_accept();
        m_exc = 0; m_eret = 0;
        if (acc) begin
            m_busy = 1; m_phase = 1;
            if (code >= 0) begin
                ip = 8'h00;
                if (code == 0) ip[NIRQ-1:0] = m_pend;
                m_exc   = 1;
                m_cause = (32'(ip) << 8) | (32'(code) << 2);
                m_excpc = ex_pc;
                m_rpc   = HANDLER;
                m_pend  = (code == 0) ? rise : (m_pend | rise);
            end else begin
                m_eret = 1;
                m_rpc  = epc;
                m_pend = m_pend | rise;
            end
        end else begin
            m_pend = m_pend | rise;
            if (m_busy && m_phase == 1) begin
                m_rv = 1; m_phase = 2;
            end else if (m_busy && m_phase == 2 && redirect_ready) begin
                m_rv = 0; m_busy = 0; m_phase = 0;
            end
        end
    endtask

    // One clock: check stall before the edge, advance model, check registered outputs.
    task automatic step();
        #1;
        check("stall", stall, (m_busy || m_accept()) ? 32'd1 : 32'd0);
        @(posedge clk);
        m_edge();
        #1;
        check("exception", exception, m_exc);
        check("eret", eret, m_eret);
        check("cause", cause, m_cause);
        check("exc_pc", exc_pc, m_excpc);
        check("redirect_valid", redirect_valid, m_rv);
        check("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic clear_ev();
        ex_valid = 1'b0; ex_syscall = 1'b0; ex_break = 1'b0; ex_teq = 1'b0; ex_eret = 1'b0;
    endtask

    typedef struct {
        logic [31:0] st;
        logic        sys, brk, teq, ert;
        logic [31:0] pc;
        logic        acc, exc;
        logic [31:0] cz;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n;
        tbl[0]  = '{32'h3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0100, 1'b1, 1'b1, 32'h20};
        tbl[1]  = '{32'h1,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0104, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{32'h5,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0108, 1'b1, 1'b1, 32'h24};
        tbl[3]  = '{32'h9,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_010C, 1'b1, 1'b1, 32'h34};
        tbl[4]  = '{32'h2,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0110, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0114, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{32'hF,  1'b1, 1'b1, 1'b1, 1'b0, 32'h0040_0118, 1'b1, 1'b1, 32'h34};
        tbl[7]  = '{32'h7,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_011C, 1'b1, 1'b1, 32'h24};
        tbl[8]  = '{32'h3,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0120, 1'b1, 1'b1, 32'h20};
        tbl[9]  = '{32'h1,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0040_0124, 1'b1, 1'b0, 32'h0};
        tbl[10] = '{32'h1F, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0128, 1'b1, 1'b1, 32'h20};

        rst = 1'b0; clear_ev(); ex_pc = 32'h0; status = 32'h0; epc = 32'h0040_0300;
        irq = '0; redirect_ready = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_exception", exception, 32'h0);
        check("rst_eret", eret, 32'h0);
        check("rst_cause", cause, 32'h0);
        check("rst_exc_pc", exc_pc, 32'h0);
        check("rst_stall", stall, 32'h0);
        check("rst_redirect_valid", redirect_valid, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1'b1;

        // Single-instruction vectors, redirect accepted immediately.
        for (int i = 0; i < 11; i++) begin
            status = tbl[i].st; ex_valid = 1'b1; ex_pc = tbl[i].pc;
            ex_syscall = tbl[i].sys; ex_break = tbl[i].brk; ex_teq = tbl[i].teq; ex_eret = tbl[i].ert;
            #1;
            check($sformatf("tbl%0d_stall_accept", i), stall, tbl[i].acc);
            step();
            clear_ev();
            check($sformatf("tbl%0d_exception", i), exception, tbl[i].exc);
            check($sformatf("tbl%0d_eret", i), eret, tbl[i].acc & ~tbl[i].exc);
            if (tbl[i].exc) begin
                check($sformatf("tbl%0d_cause", i), cause, tbl[i].cz);
                check($sformatf("tbl%0d_exc_pc", i), exc_pc, tbl[i].pc);
            end
            step();
            check($sformatf("tbl%0d_redirect_valid", i), redirect_valid, tbl[i].acc);
            if (tbl[i].acc)
                check($sformatf("tbl%0d_redirect_pc", i), redirect_pc, tbl[i].exc ? HANDLER : epc);
            step();
            check($sformatf("tbl%0d_redirect_done", i), redirect_valid, 32'h0);
        end

        // teq with redirect back-pressure.
        status = 32'h9; ex_valid = 1'b1; ex_teq = 1'b1; ex_pc = 32'h0040_0140; redirect_ready = 1'b0;
        step();
        clear_ev();
        check("teq_cause", cause, 32'h34);
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_redirect_valid", redirect_valid, 32'h1);
            check("hold_stall", stall, 32'h1);
            check("hold_redirect_pc", redirect_pc, HANDLER);
            step();
        end
        redirect_ready = 1'b1;
        check("hold_last_valid", redirect_valid, 32'h1);
        step();
        check("hold_released_valid", redirect_valid, 32'h0);
        check("hold_released_stall", stall, 32'h0);

        // Interrupt beats a simultaneous eret, then pending is gone.
        status = 32'h11; irq = 4'b0100;
        step();
        irq = 4'b0000;
        repeat (LAT) step();
        ex_valid = 1'b1; ex_eret = 1'b1; ex_pc = 32'h0040_0200;
        step();
        clear_ev();
        check("int_exception", exception, 32'h1);
        check("int_eret", eret, 32'h0);
        check("int_cause", cause, 32'h400);
        check("int_exc_pc", exc_pc, 32'h0040_0200);
        step(); step();
        ex_valid = 1'b1;
        #1;
        check("int_pending_cleared", stall, 32'h0);
        step();
        clear_ev();

        // Eret with asynchronous reset in the middle of the redirect.
        status = 32'h0; epc = 32'h0040_0300; ex_valid = 1'b1; ex_eret = 1'b1; redirect_ready = 1'b0;
        step();
        clear_ev();
        check("eret_pulse", eret, 32'h1);
        check("eret_no_exception", exception, 32'h0);
        step();
        check("eret_redirect_valid", redirect_valid, 32'h1);
        check("eret_redirect_pc", redirect_pc, 32'h0040_0300);
        rst = 1'b0;
        #1;
        check("midrst_redirect_valid", redirect_valid, 32'h0);
        check("midrst_redirect_pc", redirect_pc, 32'h0);
        check("midrst_stall", stall, 32'h0);
        check("midrst_exc_pc", exc_pc, 32'h0);
        check("midrst_cause", cause, 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; redirect_ready = 1'b1;
        step();
        check("postrst_idle", redirect_valid, 32'h0);

        // irq edge to pending latency, observed as the accept stall.
        status = 32'h11; ex_valid = 1'b1; irq = 4'b0001;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (stall) break;
        end
        check("irq_latency", n, LAT + 1);
        clear_ev(); irq = 4'b0000;
        repeat (4) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                status = $urandom;
                status[0] = ($urandom_range(3) != 0);
            end
            ex_valid   = $urandom_range(1);
            ex_syscall = ($urandom_range(3) == 0);
            ex_break   = ($urandom_range(3) == 0);
            ex_teq     = ($urandom_range(3) == 0);
            ex_eret    = ($urandom_range(3) == 0);
            ex_pc      = $urandom;
            epc        = $urandom;
            redirect_ready = $urandom_range(1);
            if ($urandom_range(7) == 0) irq = irq ^ NIRQ'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt sequencer that drives the exception-side interface of the CP0 register file.
- Watches the decode-stage instruction for syscall, break, teq-taken and eret, and latches external interrupt requests.
- Gates each event against the CP0 status enables, then generates the one-cycle exception/eret pulses, the cause word and the EPC value for CP0.
- Stalls the pipeline and issues the PC redirect (to the handler, or to EPC on eret) through a valid/ready handshake.

Parameters:
- HANDLER_ADDR, 32'h0040_0004, exception/interrupt handler entry PC.
- NUM_IRQ, 4, number of external interrupt lines (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  decode-stage instruction valid.
- ex_pc  in  32  PC of decode-stage instruction.
- ex_syscall  in  1  instruction is syscall.
- ex_break  in  1  instruction is break.
- ex_teq  in  1  instruction is teq and rs==rt.
- ex_eret  in  1  instruction is eret.
- irq  in  NUM_IRQ  level external interrupt requests.
- status  in  32  CP0 status register.
- epc  in  32  CP0 EPC register.
- exception  out  1  one-cycle pulse to CP0: record exception.
- eret  out  1  one-cycle pulse to CP0: restore status.
- cause  out  32  cause word to CP0.
- exc_pc  out  32  PC to write into EPC.
- stall  out  1  hold IF/ID pipeline.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  target PC.
- redirect_ready  in  1  fetch accepts redirect.

Behaviour:
- Enables (status bits): [0] global IE; [1] syscall; [2] break; [3] teq; [4] external interrupt.
- An event counts as enabled only when status[0] and its own bit are both 1.
- Masked events: no pulse, no stall; the instruction proceeds as a NOP.
- ExcCodes: Int=0, Sys=8, Bp=9, Tr=13.
- Cause format: [15:8] = IP snapshot (zero-extended to 8 bits), [6:2] = ExcCode, all other bits 0.
- pending[NUM_IRQ-1:0]:
  - Set on a rising edge of the (synchronised) irq line.
  - All bits cleared when an interrupt is accepted.
  - A new edge in the clear cycle wins: that bit stays set.
- int_req = |pending & status[0] & status[4].
- Priority in one cycle: int > teq > break > syscall > eret. Lower-priority events that cycle are dropped.
- States: IDLE, TRAP, ERET, REDIR.
- IDLE:
  - Accept occurs when ex_valid and (int_req or an enabled exception or ex_eret).
  - stall is combinationally 1 in the accept cycle.
  - Exception or interrupt accept: register exc_pc=ex_pc, cause (IP = pending, or 0 for non-Int), redirect_pc=HANDLER_ADDR; go to TRAP.
  - Eret accept: register redirect_pc=epc; go to ERET.
- TRAP: exception=1 for exactly this cycle; go to REDIR.
- ERET: eret=1 for exactly this cycle; go to REDIR.
- REDIR:
  - redirect_valid=1; redirect_pc held stable.
  - Transfer completes on the edge where redirect_ready=1; go to IDLE.
  - redirect_ready already 1 on the first REDIR cycle gives one-cycle REDIR.
- stall=1 in TRAP, ERET and REDIR.
- Latency: accept at edge N; exception/eret pulse in cycle N+1; redirect_valid from cycle N+2.
- Events arriving while not IDLE are ignored; the pipeline is stalled, so they re-present.
- exception and eret are never both 1.
- Reset, including mid-operation: state=IDLE, pending=0, synchroniser flops=0. Outputs exception=0, eret=0, cause=0, exc_pc=0, stall=0, redirect_valid=0, redirect_pc=0.
- exception, eret, cause, exc_pc, redirect_valid and redirect_pc are registered outputs.

Optional Feature:
- Macro: EXC_CTRL_IRQ_SYNC_EN.
- Defined: each irq bit passes through a two-flop synchroniser, then an edge detector. An irq rising before edge k sets pending at edge k+2.
- Undefined: irq is edge-detected directly against a one-flop delayed copy. Pending is set at edge k.
- All other behaviour is identical.

Test Plan:
- status=0x3, ex_valid=1, ex_syscall=1, ex_pc=0x0040_0100, redirect_ready=1:
  - exception=1 one cycle later with cause=0x0000_0020, exc_pc=0x0040_0100.
  - Next cycle redirect_valid=1, redirect_pc=0x0040_0004; stall high for 3 cycles in total.
- status=0x1, ex_break=1 (break masked): no pulse, stall=0, redirect_valid=0. With status=0x5: cause=0x0000_0024.
- status=0x9, ex_teq=1, redirect_ready held 0 for 5 cycles:
  - cause=0x0000_0034.
  - redirect_valid and stall remain 1 with redirect_pc stable until ready; return to IDLE the cycle after ready.
- status=0x11, irq=4'b0100 pulse, ex_valid=1, ex_pc=0x0040_0200, ex_eret=1 in the same cycle:
  - Interrupt wins: cause=0x0000_0400, exc_pc=0x0040_0200, eret stays 0.
  - pending cleared afterwards.
- Eret: epc=0x0040_0300, ex_eret=1 → eret=1 one cycle, then redirect_pc=0x0040_0300. Assert rst=0 during REDIR → all outputs 0 immediately, state IDLE.
- irq[0] edge to pending latency:
  - 2 extra cycles with EXC_CTRL_IRQ_SYNC_EN, 0 without.
  - Check with status=0x11, ex_valid=1.
